// File: rtl/i2s_in.sv
`default_nettype none
// ============================================================================
// Module   : i2s_in
// Desc     : I2S receiver; recovers a DSZ-bit stereo pair from sdin/sclk/lrclk.
//            Define I2S_IN_SYNC_EN to add a 2-flop synchronizer on the bus.
// Revision : 1.0  initial release
// ============================================================================
module i2s_in #(
  parameter int DSZ   = 16,
  parameter int CNTSZ = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sdin,
  input  logic           sclk,
  input  logic           lrclk,
  input  logic           err_clr,
  output logic [DSZ-1:0] l_data,
  output logic [DSZ-1:0] r_data,
  output logic           valid,
  output logic           frame_err
);

  localparam logic [CNTSZ-1:0] c_dsz_m1  = CNTSZ'(DSZ - 1);
  localparam logic [CNTSZ-1:0] c_cnt_max = '1;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [2:0]       w_bus_in;
  logic             r_sdin;
  logic             r_sclk;
  logic             r_lrclk;
  logic             r_sclk_d;
  logic             r_lr_prev;
  logic [DSZ-1:0]   r_shift;
  logic [CNTSZ-1:0] r_cnt;
  logic [DSZ-1:0]   r_l_hold;
  logic [DSZ-1:0]   r_l_data;
  logic [DSZ-1:0]   r_r_data;
  logic             r_valid;
  logic             r_frame_err;

  logic             w_bit_evt;
  logic             w_boundary;
  logic             w_take;
  logic             w_short;
  logic [DSZ-1:0]   w_bit_vec;
  logic [DSZ-1:0]   w_word;
  logic             w_cap_l;
  logic             w_cap_r;
  logic             w_set_err;

`ifdef I2S_IN_SYNC_EN
  logic [2:0] r_meta;
  logic [2:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= {sdin, sclk, lrclk};
      r_sync <= r_meta;
    end
  end

  assign w_bus_in = r_sync;
`else
  assign w_bus_in = {sdin, sclk, lrclk};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sdin   <= 1'b0;
      r_sclk   <= 1'b0;
      r_lrclk  <= 1'b0;
      r_sclk_d <= 1'b0;
    end else begin
      {r_sdin, r_sclk, r_lrclk} <= w_bus_in;
      r_sclk_d <= r_sclk;
    end
  end

  assign w_bit_evt  = r_sclk & ~r_sclk_d;
  assign w_boundary = w_bit_evt & (r_lrclk ^ r_lr_prev);

  // Bits land directly at their left-aligned position, so a short slot is
  // already zero-padded when it closes.
  assign w_take    = (r_cnt <= c_dsz_m1);
  assign w_short   = (r_cnt <  c_dsz_m1);
  assign w_bit_vec = {{(DSZ-1){1'b0}}, r_sdin} << (c_dsz_m1 - r_cnt);
  assign w_word    = w_take ? (r_shift | w_bit_vec) : r_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_l     = 1'b0;
    w_cap_r     = 1'b0;
    w_set_err   = 1'b0;
    if (w_boundary) begin
      case (r_state)
        SYNC: begin
          if (!r_lrclk) w_state_nxt = LEFT;
        end
        LEFT: begin
          w_state_nxt = RIGHT;
          w_cap_l     = 1'b1;
          w_set_err   = w_short;
        end
        RIGHT: begin
          w_state_nxt = LEFT;
          w_cap_r     = 1'b1;
          w_set_err   = w_short;
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lr_prev   <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_l_hold    <= '0;
      r_l_data    <= '0;
      r_r_data    <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid <= w_cap_r;
      if (w_bit_evt) r_lr_prev <= r_lrclk;

      // The boundary bit is the last bit of the closing slot (one-bit delay);
      // the new slot starts empty.
      if (w_boundary) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (w_bit_evt && (r_state != SYNC)) begin
        r_shift <= w_word;
        if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 1'b1;
      end

      if (w_cap_l) r_l_hold <= w_word;
      if (w_cap_r) begin
        r_r_data <= w_word;
        r_l_data <= r_l_hold;
      end

      if (w_set_err) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign l_data    = r_l_data;
  assign r_data    = r_r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_in.sv
`default_nettype none
// Testbench for i2s_in: drives directed I2S frames, scoreboard checks each
// valid strobe against hand-computed stereo pairs, error flag and latency.
module tb_i2s_in;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        sdin    = 1'b0;
  logic        sclk    = 1'b0;
  logic        lrclk   = 1'b1;
  logic        err_clr = 1'b0;
  logic [15:0] l_data;
  logic [15:0] r_data;
  logic        valid;
  logic        frame_err;

  i2s_in dut (
    .clk       (clk),
    .reset     (reset),
    .sdin      (sdin),
    .sclk      (sclk),
    .lrclk     (lrclk),
    .err_clr   (err_clr),
    .l_data    (l_data),
    .r_data    (r_data),
    .valid     (valid),
    .frame_err (frame_err)
  );

`ifdef I2S_IN_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_cmp      = 0;
  int   n_err      = 0;
  int   t_bnd      = 0;
  logic prev_lsb   = 1'b0;
  logic last_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected pair per valid strobe.
  always @(negedge clk) begin
    exp_t e;
    if (last_valid) check("valid_width", {31'b0, valid}, 32'd0);
    last_valid = (valid === 1'b1);
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("l_data", {16'b0, l_data}, {16'b0, e.l});
        check("r_data", {16'b0, r_data}, {16'b0, e.r});
        check("frame_err_at_valid", {31'b0, frame_err}, {31'b0, e.err});
        check("latency", cyc - t_bnd, LAT);
      end
    end
  end

  // One bit: sclk low 4 clk, high 4 clk; optional err_clr pulse on the edge
  // where the DUT acts on this bit.
  task automatic send_bit(input logic lr, input logic d, input logic clr, input logic mark);
    sclk  = 1'b0;
    lrclk = lr;
    sdin  = d;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    if (mark) t_bnd = cyc;
    @(negedge clk);
    err_clr = clr;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input logic [31:0] lw, input logic [31:0] rw,
                            input logic [15:0] el, input logic [15:0] er, input logic eerr,
                            input logic clr_r0, input logic clr_mid);
    exp_t e;
    e.l = el;
    e.r = er;
    e.err = eerr;
    q.push_back(e);
    for (int i = 0; i < n; i++)
      send_bit(1'b0, (i == 0) ? prev_lsb : lw[n-i], clr_mid && (i == 3), i == 0);
    for (int i = 0; i < n; i++)
      send_bit(1'b1, (i == 0) ? lw[0] : rw[n-i], clr_r0 && (i == 0), 1'b0);
    prev_lsb = rw[0];
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_l_data", {16'b0, l_data}, 32'd0);
    check("rst_r_data", {16'b0, r_data}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);

    // Startup inside a right slot: partial slot is discarded.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0);

    // Loopback-style frames, 16 sclk per channel.
    send_frame(16, 32'h1234, 32'hABCD, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0);
    send_frame(16, 32'h1234, 32'hABCD, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0);
    send_frame(16, 32'h1234, 32'hABCD, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0);
    send_frame(16, 32'h8001, 32'h7FFE, 16'h8001, 16'h7FFE, 1'b0, 1'b0, 1'b0);

    // Long slot: extra bits ignored.
    send_frame(24, 32'h89ABCD, 32'h123456, 16'h89AB, 16'h1234, 1'b0, 1'b0, 1'b0);

    // Short slots: left-aligned, zero-padded, sticky error.
    send_frame(12, 32'hFFF, 32'h0A5, 16'hFFF0, 16'h0A50, 1'b1, 1'b0, 1'b0);
    check("err_after_short", {31'b0, frame_err}, 32'd1);
    // err_clr coincides with the short left slot closing: set wins.
    send_frame(12, 32'h800, 32'h001, 16'h8000, 16'h0010, 1'b1, 1'b1, 1'b0);
    check("err_set_wins", {31'b0, frame_err}, 32'd1);
    // err_clr mid left slot, full slots afterwards.
    send_frame(16, 32'hCAFE, 32'h0F0F, 16'hCAFE, 16'h0F0F, 1'b0, 1'b0, 1'b1);
    check("err_cleared", {31'b0, frame_err}, 32'd0);

    // Reset mid left slot (closing the previous frame first).
    for (int i = 0; i < 4; i++) send_bit(1'b0, (i == 0) ? prev_lsb : 1'b1, 1'b0, i == 0);
    sclk  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_l_data", {16'b0, l_data}, 32'd0);
    check("mid_rst_r_data", {16'b0, r_data}, 32'd0);
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_frame_err", {31'b0, frame_err}, 32'd0);

    // Resync: rest of the left slot and a right slot are ignored.
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    prev_lsb = 1'b1;
    send_frame(16, 32'h5A5A, 32'hA5C3, 16'h5A5A, 16'hA5C3, 1'b0, 1'b0, 1'b0);

    // Closing boundary for the last frame.
    send_bit(1'b0, prev_lsb, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("all_pairs_seen", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
